mealy_share_ctrl: RTL and testbench

//  Round-robin controller sharing one serial Mealy pattern detector among

---
 rtl/mealy_share_ctrl.sv | 144 ++++++++++++++
 tb/tb_mealy_share_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mealy_share_ctrl.sv
// Round-robin arbiter that time-shares one serial Mealy detector.
// Each grant clears the detector, shifts a word MSB first, returns z bits.
module mealy_share_ctrl #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic            done,
  output logic [W-1:0]    result,
  output logic            det_clr,
  output logic            det_en,
  output logic            det_a,
  input  logic            det_z
);

  localparam int CW = $clog2(W + 1);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    SHIFT,
    DONE
  } state_t;

  state_t          state, state_n;
  logic [NREQ-1:0] gnt_n;
  logic            busy_n, done_n;
  logic [W-1:0]    result_n;
  logic            clr_n, en_n, a_n;
  logic [W-1:0]    shreg, shreg_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic [PW-1:0]   sel, sel_n;
  logic [PW-1:0]   pick, ix;
  logic            found;
  logic [W:0]      ext;

  assign ext = {result, det_z};

  // First requesting index at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    ix    = '0;
    for (int k = 0; k < NREQ; k++) begin
      ix = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[ix]) begin
        found = 1'b1;
        pick  = ix;
      end
    end
  end

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    busy_n   = busy;
    done_n   = 1'b0;
    result_n = result;
    clr_n    = 1'b0;
    en_n     = det_en;
    a_n      = det_a;
    shreg_n  = shreg;
    cnt_n    = cnt;
    ptr_n    = ptr;
    sel_n    = sel;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n     = CLR;
          gnt_n       = '0;
          gnt_n[pick] = 1'b1;
          sel_n       = pick;
          shreg_n     = req_data[int'(pick)*W +: W];
          cnt_n       = '0;
          busy_n      = 1'b1;
          clr_n       = 1'b1;
        end
      end
      CLR: begin
        state_n = SHIFT;
        en_n    = 1'b1;
        a_n     = shreg[W-1];
        shreg_n = shreg << 1;
      end
      SHIFT: begin
        result_n = ext[W-1:0];
        cnt_n    = cnt + 1'b1;
        if (cnt == CW'(W - 1)) begin
          state_n = DONE;
          en_n    = 1'b0;
          a_n     = 1'b0;
          done_n  = 1'b1;
          ptr_n   = (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
        end else begin
          a_n     = shreg[W-1];
          shreg_n = shreg << 1;
        end
      end
      DONE: begin
        state_n = IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      det_clr <= 1'b0;
      det_en  <= 1'b0;
      det_a   <= 1'b0;
      shreg   <= '0;
      cnt     <= '0;
      ptr     <= '0;
      sel     <= '0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      busy    <= busy_n;
      done    <= done_n;
      result  <= result_n;
      det_clr <= clr_n;
      det_en  <= en_n;
      det_a   <= a_n;
      shreg   <= shreg_n;
      cnt     <= cnt_n;
      ptr     <= ptr_n;
      sel     <= sel_n;
    end
  end

endmodule

// File: tb/tb_mealy_share_ctrl.sv
// Directed bench for mealy_share_ctrl with a "101" overlapping detector model.
// Second instance covers the W=1, NREQ=1 build.
module tb_mealy_share_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  gnt;
  logic        busy, done, det_clr, det_en, det_a, det_z;
  logic [7:0]  result;

  logic        req_b = 1'b0;
  logic [0:0]  data_b = '0;
  logic [0:0]  gnt_b, result_b;
  logic        busy_b, done_b, clr_b, en_b, a_b, z_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] ds = 2'd0;
  logic [1:0] ds_b = 2'd0;

  always #5 clk = ~clk;

  mealy_share_ctrl #(.NREQ(4), .W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .gnt(gnt), .busy(busy), .done(done), .result(result),
    .det_clr(det_clr), .det_en(det_en), .det_a(det_a), .det_z(det_z)
  );

  mealy_share_ctrl #(.NREQ(1), .W(1)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .req_data(data_b),
    .gnt(gnt_b), .busy(busy_b), .done(done_b), .result(result_b),
    .det_clr(clr_b), .det_en(en_b), .det_a(a_b), .det_z(z_b)
  );

  function automatic logic [1:0] nxt(input logic [1:0] s, input logic a);
    case (s)
      2'd1:    nxt = a ? 2'd1 : 2'd2;
      default: nxt = a ? 2'd1 : 2'd0;
    endcase
  endfunction

  function automatic logic [7:0] ref_res(input logic [7:0] d, input int w);
    logic [1:0] s;
    logic [7:0] r;
    s = 2'd0;
    r = '0;
    for (int i = w - 1; i >= 0; i--) begin
      r = {r[6:0], (s == 2'd2) && d[i]};
      s = nxt(s, d[i]);
    end
    return r;
  endfunction

  assign det_z = (ds == 2'd2) && det_a;
  assign z_b   = (ds_b == 2'd2) && a_b;

  always @(posedge clk) begin
    if (det_clr) ds <= 2'd0;
    else if (det_en) ds <= nxt(ds, det_a);
    if (clr_b) ds_b <= 2'd0;
    else if (en_b) ds_b <= nxt(ds_b, a_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    n_cmp++;
    if ({gnt, busy, done, det_clr, det_en, det_a} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_ctl got %b want 0",
               {gnt, busy, done, det_clr, det_en, det_a});
    end
    n_cmp++;
    if (result !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_result got %h want 00", result);
    end
    n_cmp++;
    if ({gnt_b, busy_b, done_b, clr_b, en_b, a_b, result_b} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_b got %b want 0",
               {gnt_b, busy_b, done_b, clr_b, en_b, a_b, result_b});
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] d;
    d = 8'hA5;
    req = 4'b0001;
    req_data = {24'h0, d};
    tick();
    n_cmp++;
    if ({gnt, busy, det_clr, det_en} !== 7'b0001_1_1_0) begin
      n_bad++;
      $display("FAIL t1_grant got %b want 0001110",
               {gnt, busy, det_clr, det_en});
    end
    req = 4'b0000;
    tick();
    n_cmp++;
    if ({det_clr, det_en} !== 2'b01) begin
      n_bad++;
      $display("FAIL t1_clr_once got %b want 01", {det_clr, det_en});
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({det_en, det_a} !== {1'b1, d[7-i]}) begin
        n_bad++;
        $display("FAIL t1_bit%0d got %b want %b", i,
                 {det_en, det_a}, {1'b1, d[7-i]});
      end
      tick();
    end
    n_cmp++;
    if ({done, det_en, result} !== {2'b10, 8'h21}) begin
      n_bad++;
      $display("FAIL t1_done got %b/%b/%h want 1/0/21", done, det_en, result);
    end
    n_cmp++;
    if (result !== ref_res(d, 8)) begin
      n_bad++;
      $display("FAIL t1_model got %h want %h", result, ref_res(d, 8));
    end
    tick();
    n_cmp++;
    if ({done, busy, gnt} !== 6'b0) begin
      n_bad++;
      $display("FAIL t1_release got %b want 0", {done, busy, gnt});
    end
  endtask

  task automatic test_round_robin();
    int who;
    do_reset();
    req = 4'b1111;
    req_data = {8'h5A, 8'hB6, 8'hAA, 8'hA5};
    for (int t = 0; t < 5; t++) begin
      who = t % 4;
      tick();
      n_cmp++;
      if (gnt !== 4'(1 << who)) begin
        n_bad++;
        $display("FAIL t2_gnt%0d got %b want %b", t, gnt, 4'(1 << who));
      end
      repeat (9) tick();
      n_cmp++;
      if (done !== 1'b1 || result !== ref_res(req_data[who*8 +: 8], 8)) begin
        n_bad++;
        $display("FAIL t2_res%0d got %b/%h want 1/%h", t, done, result,
                 ref_res(req_data[who*8 +: 8], 8));
      end
      tick();
      n_cmp++;
      if (gnt !== 4'b0 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL t2_drop%0d got %b/%b want 0000/0", t, gnt, done);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_alternate();
    int who;
    do_reset();
    req = 4'b1010;
    req_data = {8'h0F, 8'h00, 8'h55, 8'h00};
    for (int t = 0; t < 8; t++) begin
      who = (t % 2 == 0) ? 1 : 3;
      tick();
      n_cmp++;
      if (gnt !== 4'(1 << who)) begin
        n_bad++;
        $display("FAIL t3_gnt%0d got %b want %b", t, gnt, 4'(1 << who));
      end
      repeat (9) tick();
      n_cmp++;
      if (done !== 1'b1 || result !== ref_res(req_data[who*8 +: 8], 8)) begin
        n_bad++;
        $display("FAIL t3_res%0d got %b/%h want 1/%h", t, done, result,
                 ref_res(req_data[who*8 +: 8], 8));
      end
      tick();
    end
    req = 4'b0000;
  endtask

  task automatic test_abort();
    do_reset();
    req = 4'b0001;
    req_data = {24'h0, 8'hB6};
    tick();
    req = 4'b0000;
    tick();
    repeat (4) tick();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({gnt, busy, det_en, done} !== 7'b0) begin
      n_bad++;
      $display("FAIL t4_abort got %b want 0", {gnt, busy, det_en, done});
    end
    tick();
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL t4_nodone got %b want 0", done);
    end
    reset = 1'b0;
    req = 4'b0001;
    req_data = {24'h0, 8'hA5};
    tick();
    n_cmp++;
    if ({gnt, det_clr} !== 5'b0001_1) begin
      n_bad++;
      $display("FAIL t4_reclr got %b want 00011", {gnt, det_clr});
    end
    req = 4'b0000;
    repeat (9) tick();
    n_cmp++;
    if ({done, result} !== {1'b1, 8'h21}) begin
      n_bad++;
      $display("FAIL t4_res got %b/%h want 1/21", done, result);
    end
    tick();
  endtask

  task automatic test_pulse();
    int n_en, n_clr, n_done;
    logic [7:0] got;
    n_en = 0;
    n_clr = 0;
    n_done = 0;
    got = '0;
    req = 4'b0001;
    req_data = {24'h0, 8'hAA};
    tick();
    req = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      if (det_en) n_en++;
      if (det_clr) n_clr++;
      if (done) begin
        n_done++;
        got = result;
      end
      tick();
    end
    n_cmp++;
    if (n_en != 8 || n_clr != 1 || n_done != 1) begin
      n_bad++;
      $display("FAIL t5_counts got en%0d clr%0d done%0d want 8/1/1",
               n_en, n_clr, n_done);
    end
    n_cmp++;
    if (got !== 8'h2A) begin
      n_bad++;
      $display("FAIL t5_res got %h want 2a", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r;
    r = ref_res(8'h01, 1);
    req_b = 1'b1;
    data_b = 1'b1;
    tick();
    n_cmp++;
    if ({gnt_b, clr_b, busy_b} !== 3'b111) begin
      n_bad++;
      $display("FAIL t6_grant got %b want 111", {gnt_b, clr_b, busy_b});
    end
    tick();
    n_cmp++;
    if ({en_b, a_b, done_b} !== 3'b110) begin
      n_bad++;
      $display("FAIL t6_shift got %b want 110", {en_b, a_b, done_b});
    end
    tick();
    n_cmp++;
    if ({done_b, en_b, result_b} !== {2'b10, r[0]}) begin
      n_bad++;
      $display("FAIL t6_done got %b want %b", {done_b, en_b, result_b},
               {2'b10, r[0]});
    end
    tick();
    n_cmp++;
    if ({gnt_b, done_b} !== 2'b00) begin
      n_bad++;
      $display("FAIL t6_drop got %b want 00", {gnt_b, done_b});
    end
    tick();
    n_cmp++;
    if ({gnt_b, clr_b} !== 2'b11) begin
      n_bad++;
      $display("FAIL t6_regrant got %b want 11", {gnt_b, clr_b});
    end
    req_b = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_alternate();
    test_abort();
    test_pulse();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
